// File: rtl/cdc_handshake_receiver_pkg.sv
// Shared types for the toggle-handshake receiver.
// The receiver either waits for a request (IDLE) or holds a captured word (HOLD).
package cdc_handshake_receiver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/cdc_handshake_receiver_if.sv
// Source-side toggle handshake: request toggle and held data go forward, ack toggle comes back.
// The master modport belongs to the sender; the slave modport belongs to the receiver.
interface cdc_handshake_receiver_if #(
  parameter int WIDTH = 8
);

  logic             req_tgl;
  logic [WIDTH-1:0] dat;
  logic             ack_tgl;

  modport master (
    output req_tgl,
    output dat,
    input  ack_tgl
  );

  modport slave (
    input  req_tgl,
    input  dat,
    output ack_tgl
  );

endinterface

// File: rtl/cdc_sync_ff.sv
// Multi-flop bit synchroniser for a single asynchronous level/toggle input.
// All stages reset to 0 asynchronously; the output is the last stage.
module cdc_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_receiver.sv
// Destination end of a toggle req/ack handshake: synchronises the request toggle,
// captures the held source word, and presents it on a valid/ready port.
module cdc_handshake_receiver
  import cdc_handshake_receiver_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  cdc_handshake_receiver_if.slave  src_if,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_overrun,
  output logic [CNT_W-1:0]         o_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_seen;
  logic             w_req_seen_nxt;
  logic             r_ack_tgl;
  logic             w_ack_tgl_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] r_dat;
  logic [WIDTH-1:0] w_dat_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_req_sync;
  logic             w_new_req;

  cdc_sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (src_if.req_tgl),
    .o_q     (w_req_sync)
  );

  // A request is outstanding whenever the synchronised toggle differs from the last one serviced.
  assign w_new_req = w_req_sync ^ r_req_seen;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_req_seen <= 1'b0;
      r_ack_tgl  <= 1'b0;
      r_valid    <= 1'b0;
      r_dat      <= '0;
      r_overrun  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_seen <= w_req_seen_nxt;
      r_ack_tgl  <= w_ack_tgl_nxt;
      r_valid    <= w_valid_nxt;
      r_dat      <= w_dat_nxt;
      r_overrun  <= w_overrun_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_seen_nxt = r_req_seen;
    w_ack_tgl_nxt  = r_ack_tgl;
    w_valid_nxt    = r_valid;
    w_dat_nxt      = r_dat;
    w_overrun_nxt  = r_overrun;
    w_count_nxt    = r_count;
    unique case (r_state)
      IDLE: begin
        if (w_new_req) begin
          w_dat_nxt      = src_if.dat;
          w_req_seen_nxt = w_req_sync;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = HOLD;
        end
      end
      HOLD: begin
        // An early toggle is flagged but left pending in r_req_seen so IDLE services it later.
        if (w_new_req) begin
          w_overrun_nxt = 1'b1;
        end
        if (i_ready) begin
          w_valid_nxt   = 1'b0;
          w_ack_tgl_nxt = ~r_ack_tgl;
          w_count_nxt   = r_count + CNT_W'(1);
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign src_if.ack_tgl = r_ack_tgl;
  assign o_valid        = r_valid;
  assign o_dat          = r_dat;
  assign o_overrun      = r_overrun;
  assign o_count        = r_count;

endmodule

// File: tb/tb_cdc_handshake_receiver.sv
// Bench for cdc_handshake_receiver: a transaction-level sender model drives two instances
// (16-bit and 2-bit counters) in lock-step and checks delivery, ack parity, overrun and wrap.
module tb_cdc_handshake_receiver;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        valid0, valid1;
  logic [7:0]  odat0, odat1;
  logic        ovr0, ovr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int n_chk;
  int n_fail;

  // Reference model state: transfers completed since reset, ack parity, sticky overrun.
  int   exp_count;
  logic exp_ack;
  logic exp_ovr;

  cdc_handshake_receiver_if #(.WIDTH(8)) if0 ();
  cdc_handshake_receiver_if #(.WIDTH(8)) if1 ();

  cdc_handshake_receiver #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .src_if    (if0),
    .o_valid   (valid0),
    .i_ready   (ready),
    .o_dat     (odat0),
    .o_overrun (ovr0),
    .o_count   (cnt0)
  );

  cdc_handshake_receiver #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(2)) dut_w (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .src_if    (if1),
    .o_valid   (valid1),
    .i_ready   (ready),
    .o_dat     (odat1),
    .o_overrun (ovr1),
    .o_count   (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dat(input logic [7:0] d);
    if0.dat = d;
    if1.dat = d;
  endtask

  task automatic toggle_req();
    if0.req_tgl = ~if0.req_tgl;
    if1.req_tgl = ~if1.req_tgl;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ack"},    32'(if0.ack_tgl), 32'(exp_ack));
    chk({tag, "_ack_w"},  32'(if1.ack_tgl), 32'(exp_ack));
    chk({tag, "_cnt"},    32'(cnt0), 32'(exp_count % 65536));
    chk({tag, "_cnt_w"},  32'(cnt1), 32'(exp_count % 4));
    chk({tag, "_ovr"},    32'(ovr0), 32'(exp_ovr));
  endtask

  // Raises request, waits for capture; returns cycles taken (bounded).
  task automatic send_and_wait(input logic [7:0] d, output int lat);
    @(negedge clk);
    set_dat(d);
    toggle_req();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid0 && lat < 20);
  endtask

  task automatic accept_one();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    exp_ack = ~exp_ack;
    exp_count++;
  endtask

  // Full transfer with 'hold' cycles of backpressure after the word appears.
  task automatic xfer(input logic [7:0] d, input int hold);
    int lat;
    send_and_wait(d, lat);
    chk("latency", 32'(lat), 32'd3);
    chk("valid_up", 32'(valid0), 32'd1);
    chk("valid_up_w", 32'(valid1), 32'd1);
    chk("cap_dat", 32'(odat0), 32'(d));
    set_dat(8'($urandom));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid0), 32'd1);
      chk("hold_dat", 32'(odat0), 32'(d));
      chk("hold_ack", 32'(if0.ack_tgl), 32'(exp_ack));
    end
    accept_one();
    chk("valid_dn", 32'(valid0), 32'd0);
    check_state("acc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if0.req_tgl = 1'b0;
    if1.req_tgl = 1'b0;
    exp_count = 0;
    exp_ack = 1'b0;
    exp_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [7:0] w1, w2, wr;
    n_chk = 0;
    n_fail = 0;
    ready = 1'b0;
    set_dat(8'h00);
    if0.req_tgl = 1'b0;
    if1.req_tgl = 1'b0;
    do_reset();

    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_dat", 32'(odat0), 32'd0);
    check_state("rst");

    // Single word, then a 10-cycle backpressure transfer.
    xfer(8'hA5, 0);
    xfer(8'h3C, 10);

    // Four-word stream from a clean reset.
    do_reset();
    xfer(8'h11, 1);
    xfer(8'h22, 0);
    xfer(8'h33, 2);
    xfer(8'h44, 0);
    chk("stream_cnt", 32'(cnt0), 32'd4);
    chk("stream_ack", 32'(if0.ack_tgl), 32'd0);
    chk("stream_ovr", 32'(ovr0), 32'd0);

    // Wrap on the 2-bit counter: fifth transfer brings it back to 1.
    xfer(8'h55, 0);
    chk("wrap_cnt_w", 32'(cnt1), 32'd1);

    // Early toggle while holding a word.
    w1 = 8'hC1;
    w2 = 8'h7E;
    send_and_wait(w1, lat);
    chk("early_cap", 32'(odat0), 32'(w1));
    set_dat(w2);
    toggle_req();
    exp_ovr = 1'b1;
    repeat (4) @(negedge clk);
    chk("early_ovr", 32'(ovr0), 32'd1);
    chk("early_ovr_w", 32'(ovr1), 32'd1);
    chk("early_valid", 32'(valid0), 32'd1);
    chk("early_dat", 32'(odat0), 32'(w1));
    accept_one();
    chk("bubble_valid", 32'(valid0), 32'd0);
    check_state("early_acc1");
    @(negedge clk);
    chk("second_valid", 32'(valid0), 32'd1);
    chk("second_dat", 32'(odat0), 32'(w2));
    accept_one();
    check_state("early_acc2");

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 25; n++) begin
      wr = 8'($urandom);
      xfer(wr, int'($urandom_range(0, 5)));
    end

    // Reset while a word is held: outputs clear without a clock edge.
    send_and_wait(8'h9D, lat);
    chk("pre_rst_valid", 32'(valid0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid0), 32'd0);
    chk("arst_dat", 32'(odat0), 32'd0);
    chk("arst_ack", 32'(if0.ack_tgl), 32'd0);
    chk("arst_cnt", 32'(cnt0), 32'd0);
    chk("arst_ovr", 32'(ovr0), 32'd0);
    do_reset();
    xfer(8'h6B, 3);
    chk("post_rst_cnt", 32'(cnt0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
